// File: rtl/vga_fade_pkg.sv
// Shared types and constants for the VGA fade-out output stage.
// The perceptual table is only used when VGA_FADE_GAMMA_EN is defined.
package vga_fade_pkg;

    localparam int FADE_MAX = 16;
    localparam int FADE_W   = 5;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        FADE_IN  = 2'd1,
        ON       = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    localparam logic [FADE_W-1:0] GAMMA_LUT [0:FADE_MAX] = '{
        5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
        5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd14, 5'd16
    };

    // c * m / 16, saturated to 4 bits; m = 16 returns c unchanged
    function automatic logic [3:0] scale_channel(input logic [3:0] c,
                                                 input logic [FADE_W-1:0] m);
        logic [8:0] prod;
        logic [8:0] shifted;
        prod    = 9'(c) * 9'(m);
        shifted = prod >> 4;
        if (shifted > 9'd15) begin
            return 4'hF;
        end
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parameterised shift register; DEPTH = 0 degenerates to a wire.
// Every stage resets to RST_VAL so idle syncs stay high through reset.
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_regs
            logic [W-1:0] sr [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sr[i] <= RST_VAL;
                    end
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_fade_out.sv
// VGA output stage: blanking, frame-synchronous brightness fade, sync alignment.
// Optional build macro VGA_FADE_GAMMA_EN maps the step index through a perceptual table.
module vga_fade_out
    import vga_fade_pkg::*;
#(
    parameter int PIPE_DEPTH      = 2,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              visible_in,
    input  logic [3:0]        r_in,
    input  logic [3:0]        g_in,
    input  logic [3:0]        b_in,
    input  logic              blank_req,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic [FADE_W-1:0] fade_level,
    output logic              fading
);

    generate
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
            $error("vga_fade_out: PIPE_DEPTH must be 1..4");
        end
        if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255) begin : g_bad_fps
            $error("vga_fade_out: FRAMES_PER_STEP must be 1..255");
        end
    endgenerate

    localparam logic [7:0]        CNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [FADE_W-1:0] LVL_MAX  = FADE_W'(FADE_MAX);

    logic              vsync_prev;
    logic              tick;
    logic [FADE_W-1:0] level_q;
    logic [FADE_W-1:0] target;
    logic [7:0]        cnt_q;
    logic [FADE_W-1:0] mult;
    fade_state_t       state_q;
    fade_state_t       state_d;

    assign tick   = vsync_prev & ~vsync_in;
    assign target = blank_req ? '0 : LVL_MAX;

    // Level only ever moves on a vsync falling edge, so a frame never changes brightness mid-way
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev <= 1'b1;
            level_q    <= '0;
            cnt_q      <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (level_q == target) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q   <= '0;
                    level_q <= (level_q < target) ? level_q + 1'b1 : level_q - 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (level_q == target) begin
            state_d = (level_q == '0) ? OFF : ON;
        end else if (level_q < target) begin
            state_d = FADE_IN;
        end else begin
            state_d = FADE_OUT;
        end
    end

    always_comb begin
        fading     = (state_q == FADE_IN) || (state_q == FADE_OUT);
        fade_level = level_q;
    end

`ifdef VGA_FADE_GAMMA_EN
    assign mult = GAMMA_LUT[level_q];
`else
    assign mult = level_q;
`endif

    logic        s1_hsync;
    logic        s1_vsync;
    logic [11:0] s1_rgb;

    // First stage: scale and blank; later stages are pure delay
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
            s1_rgb   <= '0;
        end else begin
            s1_hsync <= hsync_in;
            s1_vsync <= vsync_in;
            if (visible_in) begin
                s1_rgb <= {scale_channel(r_in, mult),
                           scale_channel(g_in, mult),
                           scale_channel(b_in, mult)};
            end else begin
                s1_rgb <= '0;
            end
        end
    end

    vga_delay_line #(
        .W       (2),
        .DEPTH   (PIPE_DEPTH - 1),
        .RST_VAL (2'b11)
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d   ({s1_hsync, s1_vsync}),
        .q   ({hsync, vsync})
    );

    vga_delay_line #(
        .W       (12),
        .DEPTH   (PIPE_DEPTH - 1),
        .RST_VAL (12'h000)
    ) u_rgb_dly (
        .clk (clk),
        .rst (rst),
        .d   (s1_rgb),
        .q   ({r, g, b})
    );

endmodule

// File: tb/tb_vga_fade_out.sv
// Bench for vga_fade_out: two instances (1 and 2 frames per step) share stimulus;
// a reference model fills per-instance expected queues that are popped PIPE_DEPTH cycles later.
module tb_vga_fade_out;
    import vga_fade_pkg::*;

    localparam int D = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       hsync_in, vsync_in, visible_in, blank_req;
    logic [3:0] r_in, g_in, b_in;

    logic       hs_a, vs_a, fad_a, hs_b, vs_b, fad_b;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [4:0] lvl_a, lvl_b;

    vga_fade_out #(.PIPE_DEPTH(D), .FRAMES_PER_STEP(1)) dut_a (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .visible_in(visible_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .blank_req(blank_req), .hsync(hs_a), .vsync(vs_a), .r(r_a), .g(g_a),
        .b(b_a), .fade_level(lvl_a), .fading(fad_a)
    );

    vga_fade_out #(.PIPE_DEPTH(D), .FRAMES_PER_STEP(2)) dut_b (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .visible_in(visible_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .blank_req(blank_req), .hsync(hs_b), .vsync(vs_b), .r(r_b), .g(g_b),
        .b(b_b), .fade_level(lvl_b), .fading(fad_b)
    );

    // scoreboard and reference model state
    logic [13:0] exp_qa[$];
    logic [13:0] exp_qb[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int m_lvl[2];
    int m_cnt[2];
    int m_fps[2] = '{1, 2};
    bit m_fad[2];
    bit m_vprev;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_col(int c, int lvl, bit vis);
        int m;
        int p;
`ifdef VGA_FADE_GAMMA_EN
        m = int'(GAMMA_LUT[lvl]);
`else
        m = lvl;
`endif
        p = (c * m) / 16;
        if (p > 15) p = 15;
        return vis ? p : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit h, input bit v, input bit vis,
                        input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
        int  tgt;
        bit  tick;
        hsync_in   = h;
        vsync_in   = v;
        visible_in = vis;
        r_in       = rr;
        g_in       = gg;
        b_in       = bb;
        tgt  = blank_req ? 0 : 16;
        exp_qa.push_back({h, v, 4'(exp_col(rr, m_lvl[0], vis)),
                          4'(exp_col(gg, m_lvl[0], vis)), 4'(exp_col(bb, m_lvl[0], vis))});
        exp_qb.push_back({h, v, 4'(exp_col(rr, m_lvl[1], vis)),
                          4'(exp_col(gg, m_lvl[1], vis)), 4'(exp_col(bb, m_lvl[1], vis))});
        tick = m_vprev && !v;
        for (int i = 0; i < 2; i++) begin
            m_fad[i] = (m_lvl[i] != tgt);
            if (m_lvl[i] == tgt) begin
                m_cnt[i] = 0;
            end else if (tick) begin
                if (m_cnt[i] == m_fps[i] - 1) begin
                    m_cnt[i] = 0;
                    m_lvl[i] = (m_lvl[i] < tgt) ? m_lvl[i] + 1 : m_lvl[i] - 1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_vprev = v;
        @(posedge clk);
        #1;
        if (exp_qa.size() == D) check("pix_a", {hs_a, vs_a, r_a, g_a, b_a}, exp_qa.pop_front());
        if (exp_qb.size() == D) check("pix_b", {hs_b, vs_b, r_b, g_b, b_b}, exp_qb.pop_front());
        check("lvl_a", lvl_a, m_lvl[0]);
        check("lvl_b", lvl_b, m_lvl[1]);
        check("fad_a", fad_a, m_fad[0]);
        check("fad_b", fad_b, m_fad[1]);
    endtask

    // one short frame: vsync low on cycle 0, hsync low on cycle 1, visible from cycle 2
    task automatic frame(input int len, input int rr);
        for (int k = 0; k < len; k++) begin
            step(k != 1, k != 0, k >= 2,
                 (rr < 0) ? 4'($urandom_range(0, 15)) : 4'(rr),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hs", hs_b, 1);
        check("rst_vs", vs_b, 1);
        check("rst_rgb_b", {r_b, g_b, b_b}, 0);
        check("rst_rgb_a", {r_a, g_a, b_a}, 0);
        check("rst_lvl_b", lvl_b, 0);
        check("rst_lvl_a", lvl_a, 0);
        check("rst_fad_b", fad_b, 0);
        rst = 1'b0;
        exp_qa.delete();
        exp_qb.delete();
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0;
            m_cnt[i] = 0;
        end
        m_vprev = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        visible_in = 1'b0;
        r_in       = '0;
        g_in       = '0;
        b_in       = '0;
        blank_req  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // fade in from black
        repeat (8) frame(6, 15);
        check("a_lvl8", lvl_a, 8);
        check("a_r7", r_a, 7);
        check("a_fading", fad_a, 1);
        check("b_lvl4", lvl_b, 4);
        repeat (8) frame(6, 15);
        check("a_lvl16", lvl_a, 16);
        check("a_r15", r_a, 15);
        check("a_on", fad_a, 0);
        check("b_lvl8", lvl_b, 8);
        repeat (16) frame(6, -1);
        check("b_lvl16", lvl_b, 16);
        check("b_on", fad_b, 0);

        // latency: hsync pulse and colour step line up PIPE_DEPTH cycles later
        repeat (3) step(1, 1, 1, 4'd0, 4'd0, 4'd0);
        step(0, 1, 1, 4'd15, 4'd15, 4'd15);
        check("lat_h_early", hs_b, 1);
        check("lat_r_early", r_b, 0);
        step(1, 1, 1, 4'd15, 4'd15, 4'd15);
        check("lat_h", hs_b, 0);
        check("lat_r", r_b, 15);
        step(1, 1, 1, 4'd15, 4'd15, 4'd15);
        check("lat_h_after", hs_b, 1);

        // blanking outside the visible area, syncs unaffected
        step(1, 1, 0, 4'd15, 4'd15, 4'd15);
        step(0, 1, 0, 4'd15, 4'd15, 4'd15);
        check("blank_rgb", {r_b, g_b, b_b}, 0);
        step(1, 1, 0, 4'd15, 4'd15, 4'd15);
        check("blank_rgb2", {r_b, g_b, b_b}, 0);
        check("blank_hs", hs_b, 0);

        // full fade out
        blank_req = 1'b1;
        step(1, 1, 1, 4'd15, 4'd15, 4'd15);
        check("fo_fading", fad_b, 1);
        repeat (2) frame(6, -1);
        check("fo_lvl15", lvl_b, 15);
        repeat (30) frame(6, -1);
        check("fo_lvl0", lvl_b, 0);
        check("fo_off", fad_b, 0);

        // reversal mid fade-out
        blank_req = 1'b0;
        repeat (32) frame(6, -1);
        check("up_lvl16", lvl_b, 16);
        blank_req = 1'b1;
        repeat (12) frame(6, -1);
        check("rev_lvl10", lvl_b, 10);
        check("rev_fading", fad_b, 1);
        blank_req = 1'b0;
        repeat (50) step(1, 1, 1, 4'($urandom_range(0, 15)), 4'd3, 4'd9);
        check("rev_hold", lvl_b, 10);
        frame(6, -1);
        check("rev_wait", lvl_b, 10);
        frame(6, -1);
        check("rev_lvl11", lvl_b, 11);

        // reset in the middle of a fade
        blank_req = 1'b1;
        repeat (4) frame(6, -1);
        check("pre_rst_lvl9", lvl_b, 9);
        do_reset();
        blank_req = 1'b0;
        repeat (2) frame(6, 15);
        check("restart_b", lvl_b, 1);
        check("restart_a", lvl_a, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
